// File: rtl/mrav_bus_ctrl_if.sv
// ============================================================================
// mrav_bus_ctrl_if: CPU-side and peripheral-side signals of the MRAV bus. Rev 1.0
// ============================================================================
`default_nettype none

interface mrav_bus_ctrl_if #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 16
);
   logic                  cpu_read;
   logic                  cpu_write;
   logic [ADDR_WIDTH-1:0] cpu_addr;
   logic [DATA_WIDTH-1:0] cpu_wdata;
   logic [DATA_WIDTH-1:0] cpu_rdata;
   logic                  cpu_done;
   logic                  cpu_err;
   logic                  cpu_busy;

   logic [ADDR_WIDTH-1:0] per_addr;
   logic [DATA_WIDTH-1:0] per_wdata;

   logic                  mem_read;
   logic                  mem_write;
   logic [DATA_WIDTH-1:0] mem_rdata;
   logic                  mem_read_done;
   logic                  mem_write_done;

   logic                  gpio_read;
   logic                  gpio_write;
   logic [DATA_WIDTH-1:0] gpio_rdata;
   logic                  gpio_read_done;
   logic                  gpio_write_done;

   // Controller view: it is the bus master towards the peripherals.
   modport master (
      input  cpu_read, cpu_write, cpu_addr, cpu_wdata,
      output cpu_rdata, cpu_done, cpu_err, cpu_busy,
      output per_addr, per_wdata,
      output mem_read, mem_write,
      input  mem_rdata, mem_read_done, mem_write_done,
      output gpio_read, gpio_write,
      input  gpio_rdata, gpio_read_done, gpio_write_done
   );

   modport slave (
      output cpu_read, cpu_write, cpu_addr, cpu_wdata,
      input  cpu_rdata, cpu_done, cpu_err, cpu_busy,
      input  per_addr, per_wdata,
      input  mem_read, mem_write,
      output mem_rdata, mem_read_done, mem_write_done,
      input  gpio_read, gpio_write,
      output gpio_rdata, gpio_read_done, gpio_write_done
   );
endinterface

`default_nettype wire

// File: rtl/mrav_bus_ctrl.sv
// ============================================================================
// mrav_bus_ctrl: single-master CPU load/store to peripheral bus controller. Rev 1.0
// ============================================================================
`default_nettype none

module mrav_bus_ctrl #(
   parameter int                    ADDR_WIDTH = 16,
   parameter int                    DATA_WIDTH = 16,
   parameter logic [ADDR_WIDTH-1:0] MEM_SIZE   = 16'h4000,
   parameter logic [ADDR_WIDTH-1:0] GPIO_ADDR  = 16'hFF00,
   parameter int                    TIMEOUT    = 16
) (
   input  logic            clk,
   input  logic            rst,
   mrav_bus_ctrl_if.master bus
);

   localparam int                CNT_W   = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t                r_state,   w_state;
   logic                  r_is_read, w_is_read;
   logic                  r_is_gpio, w_is_gpio;
   logic [CNT_W-1:0]      r_cnt,     w_cnt;
   logic [ADDR_WIDTH-1:0] r_addr,    w_addr;
   logic [DATA_WIDTH-1:0] r_wdata,   w_wdata;
   logic [DATA_WIDTH-1:0] r_rdata,   w_rdata;
   logic                  r_err,     w_err;
   logic                  r_mem_read,   w_mem_read;
   logic                  r_mem_write,  w_mem_write;
   logic                  r_gpio_read,  w_gpio_read;
   logic                  r_gpio_write, w_gpio_write;
   logic                  w_tgt_done;
   logic [DATA_WIDTH-1:0] w_tgt_rdata;
   logic                  w_in_access;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_is_read    <= 1'b0;
         r_is_gpio    <= 1'b0;
         r_cnt        <= '0;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_rdata      <= '0;
         r_err        <= 1'b0;
         r_mem_read   <= 1'b0;
         r_mem_write  <= 1'b0;
         r_gpio_read  <= 1'b0;
         r_gpio_write <= 1'b0;
      end else begin
         r_state      <= w_state;
         r_is_read    <= w_is_read;
         r_is_gpio    <= w_is_gpio;
         r_cnt        <= w_cnt;
         r_addr       <= w_addr;
         r_wdata      <= w_wdata;
         r_rdata      <= w_rdata;
         r_err        <= w_err;
         r_mem_read   <= w_mem_read;
         r_mem_write  <= w_mem_write;
         r_gpio_read  <= w_gpio_read;
         r_gpio_write <= w_gpio_write;
      end
   end

   always_comb begin
      w_state   = r_state;
      w_is_read = r_is_read;
      w_is_gpio = r_is_gpio;
      w_cnt     = r_cnt;
      w_addr    = r_addr;
      w_wdata   = r_wdata;
      w_rdata   = r_rdata;
      w_err     = r_err;

      // Only the addressed slave's done for the latched op may end an access.
      if (r_is_gpio)
         w_tgt_done = r_is_read ? bus.gpio_read_done : bus.gpio_write_done;
      else
         w_tgt_done = r_is_read ? bus.mem_read_done : bus.mem_write_done;
      w_tgt_rdata = r_is_gpio ? bus.gpio_rdata : bus.mem_rdata;

      case (r_state)
         IDLE: begin
            if (bus.cpu_read && bus.cpu_write) begin
               w_state = RESP;
               w_err   = 1'b1;
               w_rdata = '0;
            end else if (bus.cpu_read || bus.cpu_write) begin
               w_addr    = bus.cpu_addr;
               w_wdata   = bus.cpu_wdata;
               w_is_read = bus.cpu_read;
               w_cnt     = '0;
               if (bus.cpu_addr < MEM_SIZE) begin
                  w_is_gpio = 1'b0;
                  w_state   = ACCESS;
               end else if (bus.cpu_addr == GPIO_ADDR) begin
                  w_is_gpio = 1'b1;
                  w_state   = ACCESS;
               end else begin
                  w_state = RESP;
                  w_err   = 1'b1;
                  w_rdata = '0;
               end
            end
         end
         ACCESS: begin
            if (w_tgt_done) begin
               w_state = RESP;
               w_err   = 1'b0;
               w_rdata = r_is_read ? w_tgt_rdata : '0;
            end else if (r_cnt == CNT_MAX) begin
               w_state = RESP;
               w_err   = 1'b1;
               w_rdata = '0;
            end else begin
               w_cnt = r_cnt + CNT_W'(1);
            end
         end
         RESP:    w_state = IDLE;
         default: w_state = IDLE;
      endcase

      // Strobes are registered from the next state so they drop on the done edge.
      w_in_access  = (w_state == ACCESS);
      w_mem_read   = w_in_access && !w_is_gpio &&  w_is_read;
      w_mem_write  = w_in_access && !w_is_gpio && !w_is_read;
      w_gpio_read  = w_in_access &&  w_is_gpio &&  w_is_read;
      w_gpio_write = w_in_access &&  w_is_gpio && !w_is_read;
   end

   assign bus.cpu_rdata  = r_rdata;
   assign bus.cpu_err    = r_err;
   assign bus.cpu_done   = (r_state == RESP);
   assign bus.cpu_busy   = (r_state != IDLE);
   assign bus.per_addr   = r_addr;
   assign bus.per_wdata  = r_wdata;
   assign bus.mem_read   = r_mem_read;
   assign bus.mem_write  = r_mem_write;
   assign bus.gpio_read  = r_gpio_read;
   assign bus.gpio_write = r_gpio_write;

endmodule

`default_nettype wire

// File: tb/tb_mrav_bus_ctrl.sv
// ============================================================================
// tb_mrav_bus_ctrl: scoreboard bench for the MRAV bus controller. Rev 1.0
// ============================================================================
`default_nettype none

module tb_mrav_bus_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mrav_bus_ctrl_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) bus ();

   mrav_bus_ctrl #(
      .ADDR_WIDTH(16),
      .DATA_WIDTH(16),
      .MEM_SIZE  (16'h4000),
      .GPIO_ADDR (16'hFF00),
      .TIMEOUT   (16)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   typedef struct {
      logic [15:0] rdata;
      logic        err;
      int          req_cyc;
      int          lat;
   } exp_t;

   exp_t sb[$];
   int   errors    = 0;
   int   checks    = 0;
   int   cyc       = 0;
   int   mem_cnt   = 0;
   int   mem_delay = 0;
   int   done_seen = 0;
   logic force_wdone = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) mem_cnt <= (bus.mem_read || bus.mem_write) ? mem_cnt + 1 : 0;

   // Memory answers in its mem_delay-th strobe cycle (0 = never); GPIO answers at once.
   assign bus.mem_rdata       = 16'h1234;
   assign bus.mem_read_done   = bus.mem_read && (mem_cnt + 1 == mem_delay);
   assign bus.mem_write_done  = (bus.mem_write && (mem_cnt + 1 == mem_delay)) || force_wdone;
   assign bus.gpio_rdata      = 16'hBEEF;
   assign bus.gpio_read_done  = bus.gpio_read;
   assign bus.gpio_write_done = bus.gpio_write;

   task automatic run_monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         if (bus.cpu_done === 1'b1) begin
            done_seen++;
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_done: cpu_done=1 at cycle %0d, required no completion", cyc);
            end else begin
               e = sb.pop_front();
               checks++;
               if (bus.cpu_rdata !== e.rdata) begin
                  errors++;
                  $display("FAIL resp_rdata: got %h, expected %h", bus.cpu_rdata, e.rdata);
               end
               checks++;
               if (bus.cpu_err !== e.err) begin
                  errors++;
                  $display("FAIL resp_err: got %b, expected %b", bus.cpu_err, e.err);
               end
               checks++;
               if ((cyc - e.req_cyc) !== e.lat) begin
                  errors++;
                  $display("FAIL resp_latency: got %0d, expected %0d", cyc - e.req_cyc, e.lat);
               end
            end
         end
      end
   endtask

   // Drives a one-cycle request (cycle 0) and returns 1 time unit into cycle 1.
   task automatic issue(input logic rd, input logic wr, input logic [15:0] a,
                        input logic [15:0] d, input logic [15:0] er, input logic ee,
                        input int el, input bit expect_resp);
      @(posedge clk); #1;
      if (expect_resp) sb.push_back('{er, ee, cyc, el});
      bus.cpu_read  = rd;
      bus.cpu_write = wr;
      bus.cpu_addr  = a;
      bus.cpu_wdata = d;
      @(posedge clk); #1;
      bus.cpu_read  = 1'b0;
      bus.cpu_write = 1'b0;
   endtask

   task automatic test_reset();
      bus.cpu_read  = 1'b0;
      bus.cpu_write = 1'b0;
      bus.cpu_addr  = '0;
      bus.cpu_wdata = '0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({bus.cpu_rdata, bus.cpu_done, bus.cpu_err, bus.cpu_busy, bus.per_addr, bus.per_wdata,
           bus.mem_read, bus.mem_write, bus.gpio_read, bus.gpio_write} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: rdata=%h done=%b err=%b busy=%b addr=%h wdata=%h strobes=%b%b%b%b, expected all 0",
                  bus.cpu_rdata, bus.cpu_done, bus.cpu_err, bus.cpu_busy, bus.per_addr, bus.per_wdata,
                  bus.mem_read, bus.mem_write, bus.gpio_read, bus.gpio_write);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.cpu_busy !== 1'b0 || bus.cpu_done !== 1'b0) begin
         errors++;
         $display("FAIL idle_after_reset: busy=%b done=%b, expected 0 0", bus.cpu_busy, bus.cpu_done);
      end
   endtask

   task automatic test_gpio_write();
      int          cnt = 0;
      int          first = -1;
      logic        other = 1'b0;
      logic [15:0] pw = '0;
      logic        busy1 = 1'b0;
      logic        busy3 = 1'b1;
      mem_delay = 0;
      issue(1'b0, 1'b1, 16'hFF00, 16'h00A5, 16'h0000, 1'b0, 2, 1'b1);
      for (int n = 1; n <= 4; n++) begin
         @(negedge clk);
         if (bus.gpio_write === 1'b1) begin
            cnt++;
            if (first < 0) first = n;
         end
         if (bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0 || bus.gpio_read !== 1'b0) other = 1'b1;
         if (n == 1) begin
            pw    = bus.per_wdata;
            busy1 = bus.cpu_busy;
         end
         if (n == 3) busy3 = bus.cpu_busy;
      end
      checks++;
      if (cnt !== 1 || first !== 1) begin
         errors++;
         $display("FAIL gpio_write_strobe: %0d cycles from cycle %0d, expected 1 cycle from cycle 1", cnt, first);
      end
      checks++;
      if (other !== 1'b0) begin
         errors++;
         $display("FAIL gpio_write_other_strobes: got %b, expected 0", other);
      end
      checks++;
      if (pw !== 16'h00A5) begin
         errors++;
         $display("FAIL gpio_per_wdata: got %h, expected 00a5", pw);
      end
      checks++;
      if (busy1 !== 1'b1 || busy3 !== 1'b0) begin
         errors++;
         $display("FAIL gpio_busy: cycle1=%b cycle3=%b, expected 1 0", busy1, busy3);
      end
   endtask

   task automatic test_mem_read_wait();
      int cnt = 0;
      int first = -1;
      int last = -1;
      mem_delay = 3;
      issue(1'b1, 1'b0, 16'h0010, 16'h0000, 16'h1234, 1'b0, 4, 1'b1);
      for (int n = 1; n <= 6; n++) begin
         @(negedge clk);
         if (bus.mem_read === 1'b1) begin
            cnt++;
            if (first < 0) first = n;
            last = n;
         end
      end
      checks++;
      if (cnt !== 3 || first !== 1 || last !== 3) begin
         errors++;
         $display("FAIL mem_read_strobe: %0d cycles %0d..%0d, expected 3 cycles 1..3", cnt, first, last);
      end
   endtask

   task automatic test_unmapped();
      logic any = 1'b0;
      issue(1'b1, 1'b0, 16'h8000, 16'h0000, 16'h0000, 1'b1, 1, 1'b1);
      for (int n = 1; n <= 3; n++) begin
         @(negedge clk);
         if (bus.mem_read || bus.mem_write || bus.gpio_read || bus.gpio_write) any = 1'b1;
      end
      issue(1'b1, 1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1, 1'b1);
      for (int n = 1; n <= 3; n++) begin
         @(negedge clk);
         if (bus.mem_read || bus.mem_write || bus.gpio_read || bus.gpio_write) any = 1'b1;
      end
      checks++;
      if (any !== 1'b0) begin
         errors++;
         $display("FAIL error_req_strobe: got strobe=%b, expected 0", any);
      end
   endtask

   task automatic test_timeout();
      for (int pass = 0; pass < 2; pass++) begin
         int cnt = 0;
         int first = -1;
         int last = -1;
         mem_delay = (pass == 0) ? 0 : 16;
         issue(1'b0, 1'b1, 16'h0020, 16'h55AA, 16'h0000, (pass == 0), 17, 1'b1);
         for (int n = 1; n <= 19; n++) begin
            @(negedge clk);
            if (bus.mem_write === 1'b1) begin
               cnt++;
               if (first < 0) first = n;
               last = n;
            end
         end
         checks++;
         if (cnt !== 16 || first !== 1 || last !== 16) begin
            errors++;
            $display("FAIL timeout_strobe pass %0d: %0d cycles %0d..%0d, expected 16 cycles 1..16",
                     pass, cnt, first, last);
         end
      end
   endtask

   task automatic test_busy_ignore();
      logic        gpio_any = 1'b0;
      logic        mw_any = 1'b0;
      logic [15:0] pa = '0;
      int          d0;
      mem_delay = 5;
      issue(1'b1, 1'b0, 16'h0100, 16'h0000, 16'h1234, 1'b0, 6, 1'b1);
      d0 = done_seen;
      bus.cpu_write = 1'b1;
      bus.cpu_addr  = 16'hFF00;
      bus.cpu_wdata = 16'h0F0F;
      force_wdone   = 1'b1;
      for (int n = 1; n <= 8; n++) begin
         @(negedge clk);
         if (bus.gpio_write || bus.gpio_read) gpio_any = 1'b1;
         if (bus.mem_write === 1'b1) mw_any = 1'b1;
         if (n == 2) bus.cpu_write = 1'b0;
         if (n == 3) force_wdone = 1'b0;
         if (n == 5) pa = bus.per_addr;
      end
      checks++;
      if (gpio_any !== 1'b0 || mw_any !== 1'b0) begin
         errors++;
         $display("FAIL busy_ignored_req: gpio=%b mem_write=%b, expected 0 0", gpio_any, mw_any);
      end
      checks++;
      if (pa !== 16'h0100) begin
         errors++;
         $display("FAIL busy_per_addr: got %h, expected 0100", pa);
      end
      checks++;
      if (done_seen - d0 !== 1) begin
         errors++;
         $display("FAIL busy_done_count: got %0d, expected 1", done_seen - d0);
      end
   endtask

   task automatic test_reset_abort();
      int d0;
      mem_delay = 0;
      issue(1'b1, 1'b0, 16'h0200, 16'h0000, 16'h0000, 1'b0, 0, 1'b0);
      d0 = done_seen;
      @(negedge clk);
      checks++;
      if (bus.mem_read !== 1'b1 || bus.cpu_busy !== 1'b1) begin
         errors++;
         $display("FAIL abort_pre: mem_read=%b busy=%b, expected 1 1", bus.mem_read, bus.cpu_busy);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (bus.mem_read !== 1'b0 || bus.cpu_busy !== 1'b0 || bus.cpu_done !== 1'b0) begin
         errors++;
         $display("FAIL abort_reset_edge: mem_read=%b busy=%b done=%b, expected 0 0 0",
                  bus.mem_read, bus.cpu_busy, bus.cpu_done);
      end
      checks++;
      if (bus.cpu_rdata !== 16'h0000 || bus.per_addr !== 16'h0000) begin
         errors++;
         $display("FAIL abort_reset_regs: rdata=%h per_addr=%h, expected 0000 0000", bus.cpu_rdata, bus.per_addr);
      end
      rst = 1'b0;
      repeat (5) @(negedge clk);
      checks++;
      if (done_seen !== d0) begin
         errors++;
         $display("FAIL abort_no_done: got %0d completions, expected 0", done_seen - d0);
      end
      issue(1'b1, 1'b0, 16'hFF00, 16'h0000, 16'hBEEF, 1'b0, 2, 1'b1);
      repeat (4) @(negedge clk);
   endtask

   initial begin
      fork
         run_monitor();
      join_none
      test_reset();
      test_gpio_write();
      test_mem_read_wait();
      test_unmapped();
      test_timeout();
      test_busy_ignore();
      test_reset_abort();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL missing_done: %0d responses outstanding, expected 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
